// File: rtl/rat_superscalar_pkg.sv
// Shared types for the register alias table: per-slot dispatch bundle and CDB port bundle.
package rat_superscalar_pkg;

  localparam int RAT_PRB       = 6;
  localparam int RAT_ARCH_REGS = 32;
  localparam int ARCH_IDX_BITS = $clog2(RAT_ARCH_REGS);

  typedef struct packed {
    logic                     we;
    logic [ARCH_IDX_BITS-1:0] rd;
    logic [RAT_PRB-1:0]       pd;
    logic [ARCH_IDX_BITS-1:0] rs1;
    logic [ARCH_IDX_BITS-1:0] rs2;
    logic                     rs2_used;
  } rat_disp_t;

  typedef struct packed {
    logic                     valid;
    logic [ARCH_IDX_BITS-1:0] rd;
    logic [RAT_PRB-1:0]       pd;
  } cdb_port_t;

endpackage

// File: rtl/rat_src_lookup.sv
// Source operand resolution for one dispatch slot: older-slot bypass, same-cycle CDB wakeup, x0 forcing.
module rat_src_lookup
  import rat_superscalar_pkg::*;
#(
  parameter int SLOT           = 0,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_PORTS      = 3,
  parameter int PHYS_REG_BITS  = RAT_PRB
) (
  input  logic [ARCH_IDX_BITS-1:0]                     src,
  input  logic                                         src_used,
  input  logic [DISPATCH_WIDTH-1:0]                    older_we,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_IDX_BITS-1:0] older_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REG_BITS-1:0] older_pd,
  input  cdb_port_t                                    cdb [CDB_PORTS],
  input  logic [PHYS_REG_BITS-1:0]                     map_tag,
  input  logic                                         map_valid,
  output logic [PHYS_REG_BITS-1:0]                     tag,
  output logic                                         ready
);

  always_comb begin
    tag   = map_tag;
    ready = map_valid;
    for (int c = 0; c < CDB_PORTS; c++) begin
      if (cdb[c].valid && cdb[c].rd == src && cdb[c].pd == map_tag) ready = 1'b1;
    end
    // Ascending scan so the youngest older writer of src wins.
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (i < SLOT && older_we[i] && older_rd[i] == src) begin
        tag   = older_pd[i];
        ready = 1'b0;
      end
    end
    if (src == '0) begin
      tag   = '0;
      ready = 1'b1;
    end
    if (!src_used) ready = 1'b1;
  end

endmodule

// File: rtl/rat_superscalar.sv
// Register alias table: arch->phys map with ready bits, multi-slot rename, CDB wakeup and RRAT restore.
module rat_superscalar
  import rat_superscalar_pkg::*;
#(
  parameter int PHYS_REG_BITS  = RAT_PRB,
  parameter int ARCH_REGS      = RAT_ARCH_REGS,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_PORTS      = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DISPATCH_WIDTH-1:0]                    disp_we,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_IDX_BITS-1:0] disp_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REG_BITS-1:0] disp_pd,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_IDX_BITS-1:0] disp_rs1,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_IDX_BITS-1:0] disp_rs2,
  input  logic [DISPATCH_WIDTH-1:0]                    disp_rs2_used,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REG_BITS-1:0] ps1,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REG_BITS-1:0] ps2,
  output logic [DISPATCH_WIDTH-1:0]                    ps1_valid,
  output logic [DISPATCH_WIDTH-1:0]                    ps2_valid,
  input  logic [CDB_PORTS-1:0]                         cdb_valid,
  input  logic [CDB_PORTS-1:0][ARCH_IDX_BITS-1:0]      cdb_rd,
  input  logic [CDB_PORTS-1:0][PHYS_REG_BITS-1:0]      cdb_pd,
  input  logic                                         flush,
  input  logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0]      rrat_map,
  output logic                                         rat_ready
);

  logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] map_q, map_d;
  logic [ARCH_REGS-1:0]                    valid_q, valid_d;

  rat_disp_t disp [DISPATCH_WIDTH];
  cdb_port_t cdb  [CDB_PORTS];

  // x0 is hardwired, so the RRAT's x0 slot is intentionally never loaded.
  logic unused_rrat_x0;
  assign unused_rrat_x0 = ^rrat_map[0];

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      disp[i] = '{we: disp_we[i], rd: disp_rd[i], pd: disp_pd[i],
                  rs1: disp_rs1[i], rs2: disp_rs2[i], rs2_used: disp_rs2_used[i]};
    end
    for (int c = 0; c < CDB_PORTS; c++) begin
      cdb[c] = '{valid: cdb_valid[c], rd: cdb_rd[c], pd: cdb_pd[c]};
    end
  end

  assign rat_ready = ~flush;

  // Wakeup first, then renames overwrite it: a same-cycle rename beats a CDB hit on the old tag.
  always_comb begin
    map_d   = map_q;
    valid_d = valid_q;
    for (int c = 0; c < CDB_PORTS; c++) begin
      if (cdb[c].valid && cdb[c].rd != '0 && cdb[c].pd == map_q[cdb[c].rd])
        valid_d[cdb[c].rd] = 1'b1;
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (disp[i].we && disp[i].rd != '0) begin
        map_d[disp[i].rd]   = disp[i].pd;
        valid_d[disp[i].rd] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHYS_REG_BITS'(i);
      valid_q <= '1;
    end else if (flush) begin
      for (int i = 1; i < ARCH_REGS; i++) map_q[i] <= rrat_map[i];
      valid_q <= '1;
    end else begin
      map_q   <= map_d;
      valid_q <= valid_d;
    end
  end

  for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_slot
    rat_src_lookup #(
      .SLOT(j), .DISPATCH_WIDTH(DISPATCH_WIDTH), .CDB_PORTS(CDB_PORTS), .PHYS_REG_BITS(PHYS_REG_BITS)
    ) u_rs1 (
      .src      (disp[j].rs1),
      .src_used (1'b1),
      .older_we (disp_we),
      .older_rd (disp_rd),
      .older_pd (disp_pd),
      .cdb      (cdb),
      .map_tag  (map_q[disp[j].rs1]),
      .map_valid(valid_q[disp[j].rs1]),
      .tag      (ps1[j]),
      .ready    (ps1_valid[j])
    );

    rat_src_lookup #(
      .SLOT(j), .DISPATCH_WIDTH(DISPATCH_WIDTH), .CDB_PORTS(CDB_PORTS), .PHYS_REG_BITS(PHYS_REG_BITS)
    ) u_rs2 (
      .src      (disp[j].rs2),
      .src_used (disp[j].rs2_used),
      .older_we (disp_we),
      .older_rd (disp_rd),
      .older_pd (disp_pd),
      .cdb      (cdb),
      .map_tag  (map_q[disp[j].rs2]),
      .map_valid(valid_q[disp[j].rs2]),
      .tag      (ps2[j]),
      .ready    (ps2_valid[j])
    );
  end

endmodule
